// File: rtl/i_cache_2way_if.sv
// Fetch-side and memory-side bundle of the 2-way instruction cache.
// slave: cache view; master: fetch stage plus memory bridge view.
interface i_cache_2way_if #(
  parameter int A_WIDTH = 32
);
  logic [A_WIDTH-1:0] p_a;
  logic               p_strobe;
  logic               p_flush;
  logic               inv_all;
  logic [31:0]        p_din;
  logic               p_ready;
  logic               cache_miss;
  logic [A_WIDTH-1:0] m_a;
  logic               m_strobe;
  logic [31:0]        m_dout;
  logic               m_ready;

  modport slave (
    input  p_a, p_strobe, p_flush, inv_all,
    input  m_dout, m_ready,
    output p_din, p_ready, cache_miss,
    output m_a, m_strobe
  );

  modport master (
    output p_a, p_strobe, p_flush, inv_all,
    output m_dout, m_ready,
    input  p_din, p_ready, cache_miss,
    input  m_a, m_strobe
  );
endinterface

// File: rtl/i_cache_2way.sv
// 2-way set-associative I-cache, LRU replacement, burst line refill.
// Ports: clk, rst (sync, active-high), bus (i_cache_2way_if.slave).
module i_cache_2way #(
  parameter int A_WIDTH  = 32,
  parameter int C_INDEX  = 6,
  parameter int C_OFFSET = 2
) (
  input logic           clk,
  input logic           rst,
  i_cache_2way_if.slave bus
);
  localparam int T_WIDTH = A_WIDTH - C_INDEX - C_OFFSET - 2;
  localparam int WORDS   = 1 << C_OFFSET;
  localparam int SETS    = 1 << C_INDEX;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                      state;
  logic [SETS-1:0]             vld0, vld1, lru;
  logic [T_WIDTH-1:0]          tag0 [SETS];
  logic [T_WIDTH-1:0]          tag1 [SETS];
  logic [31:0]                 dat0 [SETS][WORDS];
  logic [31:0]                 dat1 [SETS][WORDS];
  logic [C_OFFSET-1:0]         cnt;
  logic [T_WIDTH+C_INDEX-1:0]  miss_a;
  logic                        victim;
  logic                        strobe_q;
  logic                        inv_pend;

  logic [T_WIDTH-1:0]  tag;
  logic [C_INDEX-1:0]  set;
  logic [C_OFFSET-1:0] word;
  logic [C_INDEX-1:0]  m_set;
  logic [T_WIDTH-1:0]  m_tag;
  logic hit0, hit1, hit, idle;
  logic miss_go, vict, beat, last;
  logic unused_ok;

  assign tag   = bus.p_a[A_WIDTH-1:C_INDEX+C_OFFSET+2];
  assign set   = bus.p_a[C_INDEX+C_OFFSET+1:C_OFFSET+2];
  assign word  = bus.p_a[C_OFFSET+1:2];
  assign m_set = miss_a[C_INDEX-1:0];
  assign m_tag = miss_a[T_WIDTH+C_INDEX-1:C_INDEX];
  assign unused_ok = ^bus.p_a[1:0];

  assign hit0 = vld0[set] && (tag0[set] == tag);
  assign hit1 = vld1[set] && (tag1[set] == tag);
  assign hit  = hit0 | hit1;
  assign idle = (state == IDLE);

  assign bus.p_ready    = idle & bus.p_strobe & hit;
  assign bus.p_din      = hit1 ? dat1[set][word] : dat0[set][word];
  assign bus.cache_miss = ~idle | (bus.p_strobe & ~hit);
  assign bus.m_strobe   = strobe_q;
  assign bus.m_a        = {miss_a, cnt, 2'b00};

  assign miss_go = idle & bus.p_strobe & ~hit
                 & ~bus.p_flush & ~bus.inv_all;
  assign vict = ~vld0[set] ? 1'b0 :
                ~vld1[set] ? 1'b1 : lru[set];
  assign beat = ~idle & bus.m_ready;
  assign last = beat && (cnt == C_OFFSET'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vld0     <= '0;
      vld1     <= '0;
      lru      <= '0;
      cnt      <= '0;
      miss_a   <= '0;
      victim   <= 1'b0;
      strobe_q <= 1'b0;
      inv_pend <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.p_strobe && hit)
            lru[set] <= ~hit1;
          if (miss_go) begin
            state    <= REFILL;
            miss_a   <= {tag, set};
            cnt      <= '0;
            victim   <= vict;
            strobe_q <= 1'b1;
            // victim is dead until its last beat lands
            if (vict) vld1[set] <= 1'b0;
            else      vld0[set] <= 1'b0;
          end
          if (bus.inv_all) begin
            vld0 <= '0;
            vld1 <= '0;
          end
        end
        REFILL: begin
          if (bus.inv_all)
            inv_pend <= 1'b1;
          if (bus.m_ready)
            cnt <= cnt + 1'b1;
          if (last) begin
            state    <= IDLE;
            strobe_q <= 1'b0;
            inv_pend <= 1'b0;
            lru[m_set] <= ~victim;
            if (victim) vld1[m_set] <= 1'b1;
            else        vld0[m_set] <= 1'b1;
            // a deferred invalidate also kills the fresh line
            if (inv_pend || bus.inv_all) begin
              vld0 <= '0;
              vld1 <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      if (victim) dat1[m_set][cnt] <= bus.m_dout;
      else        dat0[m_set][cnt] <= bus.m_dout;
    end
    if (last) begin
      if (victim) tag1[m_set] <= m_tag;
      else        tag0[m_set] <= m_tag;
    end
  end
endmodule
